priority_arbiter_n: RTL and testbench



---
 rtl/priority_arbiter_n.sv | 115 +++++++++++
 tb/tb_priority_arbiter_n.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_n.sv
// N-way registered arbiter: fixed left-priority with preemption, or round-robin with forced release.
// Grants stay visible for at least MIN_HOLD cycles; round-robin owners are forced off after MAX_HOLD while others wait.
module priority_arbiter_n #(
    parameter int N        = 4,
    parameter int MIN_HOLD = 2,
    parameter int MAX_HOLD = 8,
    parameter int CW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          mode,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [CW-1:0] grant_idx,
    output logic          grant_change
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] MIN_H = HW'(MIN_HOLD);
    localparam logic [HW-1:0] MAX_H = HW'(MAX_HOLD);
    localparam logic [N-1:0]  ONE   = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state, state_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [CW-1:0] ptr, ptr_n;
    logic [N-1:0]  grant_n;
    logic [CW-1:0] idx_n;
    logic [N-1:0]  others, cand;
    logic [CW-1:0] win;
    logic          higher, release_now, take;

    // Highest set index wins.
    function automatic logic [CW-1:0] pick_fixed(input logic [N-1:0] c);
        logic [CW-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++)
            if (c[i]) w = CW'(i);
        return w;
    endfunction

    // Search order ptr+1 .. ptr+N (mod N); scanning backwards lets the earliest hit overwrite.
    function automatic logic [CW-1:0] pick_rr(input logic [N-1:0] c, input logic [CW-1:0] p);
        logic [CW-1:0] w;
        int            j;
        w = '0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(p) + k) % N;
            if (c[j]) w = CW'(j);
        end
        return w;
    endfunction

    always_comb begin
        state_n = state;
        grant_n = grant;
        idx_n   = grant_idx;
        hold_n  = hold_cnt;
        ptr_n   = ptr;

        others = req & ~grant;
        higher = 1'b0;
        for (int i = 0; i < N; i++)
            if (i > int'(grant_idx) && req[i]) higher = 1'b1;

        release_now = (hold_cnt >= MIN_H) &&
                      (!req[grant_idx] ||
                       (!mode && higher) ||
                       (mode && hold_cnt >= MAX_H && (|others)));

        cand = (state == IDLE) ? req : others;
        win  = mode ? pick_rr(cand, ptr) : pick_fixed(cand);
        take = (state == IDLE) ? (|req) : release_now;

        if (take) begin
            if (|cand) begin
                grant_n = ONE << win;
                idx_n   = win;
                hold_n  = HW'(1);
                ptr_n   = win;
                state_n = HOLD;
            end else begin
                grant_n = '0;
                idx_n   = '0;
                hold_n  = '0;
                state_n = IDLE;
            end
        end else if (state == HOLD && hold_cnt < MAX_H) begin
            hold_n = hold_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            ptr          <= CW'(N - 1);
            grant        <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_change <= 1'b0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_n;
            ptr          <= ptr_n;
            grant        <= grant_n;
            grant_valid  <= |grant_n;
            grant_idx    <= idx_n;
            grant_change <= (grant_n != grant);
        end
    end

endmodule

// File: tb/tb_priority_arbiter_n.sv
// Directed bench for priority_arbiter_n (N=4, MIN_HOLD=2, MAX_HOLD=8).
module tb_priority_arbiter_n;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       mode;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       grant_change;

    int checks = 0;
    int errors = 0;

    priority_arbiter_n #(.N(4), .MIN_HOLD(2), .MAX_HOLD(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .mode         (mode),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_change (grant_change)
    );

    always #5 clk = ~clk;

    // Grant must be zero or one-hot, and grant_valid must track it.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(grant) || grant_valid !== (|grant)) begin
            errors++;
            $display("FAIL invariant t=%0t grant=%b grant_valid=%b", $time, grant, grant_valid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        mode = 1'b1; req = 4'b1111; reset = 1'b1;
        tick(); tick();
        checks++;
        if ({grant, grant_valid, grant_idx, grant_change} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state grant=%b valid=%b idx=%0d change=%b expected all 0",
                     grant, grant_valid, grant_idx, grant_change);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0 || grant_change !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_rr grant=%b idx=%0d change=%b expected 0001 0 1", grant, grant_idx, grant_change);
        end
        mode = 1'b0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
            errors++;
            $display("FAIL reset_first_fixed grant=%b idx=%0d expected 1000 3", grant, grant_idx);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0; req = 4'b0101;
        tick();
        checks++;
        if (grant !== 4'b0100 || grant_idx !== 2'd2 || grant_change !== 1'b1) begin
            errors++;
            $display("FAIL fixed_grant grant=%b idx=%0d change=%b expected 0100 2 1", grant, grant_idx, grant_change);
        end
        tick();
        checks++;
        if (grant !== 4'b0100 || grant_change !== 1'b0) begin
            errors++;
            $display("FAIL fixed_steady grant=%b change=%b expected 0100 0", grant, grant_change);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || grant_change !== 1'b1) begin
            errors++;
            $display("FAIL fixed_release grant=%b change=%b expected 0000 1", grant, grant_change);
        end
        tick();
        checks++;
        if (grant !== 4'b0000 || grant_change !== 1'b0 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL idle_steady grant=%b change=%b idx=%0d expected 0000 0 0", grant, grant_change, grant_idx);
        end
    endtask

    task automatic test_min_hold();
        do_reset();
        mode = 1'b0; req = 4'b0010;
        tick();
        req = 4'b0000;
        checks++;
        if (grant !== 4'b0010 || grant_change !== 1'b1) begin
            errors++;
            $display("FAIL min_hold_c1 grant=%b change=%b expected 0010 1", grant, grant_change);
        end
        tick();
        checks++;
        if (grant !== 4'b0010 || grant_change !== 1'b0) begin
            errors++;
            $display("FAIL min_hold_c2 grant=%b change=%b expected 0010 0", grant, grant_change);
        end
        tick();
        checks++;
        if (grant !== 4'b0000 || grant_change !== 1'b1) begin
            errors++;
            $display("FAIL min_hold_end grant=%b change=%b expected 0000 1", grant, grant_change);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        mode = 1'b0; req = 4'b0001;
        tick(); tick(); tick();
        req = 4'b1001;
        tick();
        checks++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3 || grant_change !== 1'b1) begin
            errors++;
            $display("FAIL preempt grant=%b idx=%0d change=%b expected 1000 3 1", grant, grant_idx, grant_change);
        end
        req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL preempt_hold grant=%b expected 1000", grant);
        end
        tick();
        checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0 || grant_change !== 1'b1) begin
            errors++;
            $display("FAIL preempt_return grant=%b idx=%0d change=%b expected 0001 0 1", grant, grant_idx, grant_change);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0001) begin
                errors++;
                $display("FAIL fixed_no_max c=%0d grant=%b expected 0001", c, grant);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        mode = 1'b1; req = 4'b1111;
        tick();
        for (int s = 0; s < 5; s++) begin
            exp_g = 4'b0001 << (s % 4);
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (grant !== exp_g || grant_change !== (c == 0)) begin
                    errors++;
                    $display("FAIL rr_seq s=%0d c=%0d grant=%b change=%b expected %b %b",
                             s, c, grant, grant_change, exp_g, (c == 0));
                end
                tick();
            end
        end
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0100) begin
                errors++;
                $display("FAIL rr_lone c=%0d grant=%b expected 0100", c, grant);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mode = 1'b1; req = 4'b0110;
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_first grant=%b expected 0010", grant);
        end
        tick();
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100 || grant_idx !== 2'd2 || grant_change !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handover grant=%b idx=%0d change=%b expected 0100 2 1", grant, grant_idx, grant_change);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        mode = 1'b1; req = 4'b0010;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (grant !== 4'b0000 || grant_change !== 1'b0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset grant=%b change=%b valid=%b expected 0000 0 0", grant, grant_change, grant_valid);
        end
        req = 4'b1111;
        tick();
        checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_ptr grant=%b idx=%0d expected 0001 0", grant, grant_idx);
        end
    endtask

    initial begin
        reset = 1'b1; req = 4'b0000; mode = 1'b0;
        test_reset();
        test_fixed();
        test_min_hold();
        test_preempt();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
